fetch_controller: RTL and testbench

Sequences instruction fetch from the byte-wide program image into the decode stage. Reads the image length from byte 0 and assembles little-endian 32-bit instructions from consecutive bytes. Presents each instruction with its byte PC over a valid/ready handshake and honours PC redirects from downstream. Sits between the byte ROM and `decode_stage`, replacing the testbench-driven fetch loop and its hand-generated clock.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_controller_if.sv | 24 ++
 rtl/fetch_controller.sv | 138 +++++++++++++
 tb/tb_fetch_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and bounds helper for the fetch path
package fetch_pkg;

   localparam int BYTE_SIZE   = 8;
   localparam int INSTR_BYTES = 4;
   localparam int INSTR_SIZE  = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_RD,
      S_LEN_CAP,
      S_FETCH,
      S_PRESENT,
      S_DONE
   } fetch_state_t;

   // A whole word at pc must end inside the image and inside the ROM
   function automatic logic word_fits(input int pc, input int len, input int mem_bytes);
      return ((pc + INSTR_BYTES) <= len) && ((pc + INSTR_BYTES) <= mem_bytes);
   endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - instruction handshake and PC redirect bus toward decode
interface fetch_controller_if #(
   parameter int ADDR_W = 7
);
   import fetch_pkg::*;

   logic [INSTR_SIZE-1:0] instr;
   logic [ADDR_W-1:0]     instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  redirect_valid;
   logic [ADDR_W-1:0]     redirect_pc;

   modport master (
      output instr, instr_pc, instr_valid,
      input  instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  instr, instr_pc, instr_valid,
      output instr_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - byte-serial little-endian instruction fetch with PC redirect
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   output logic [ADDR_W-1:0]    o_mem_addr,
   input  logic [BYTE_SIZE-1:0] i_mem_rdata,
   output logic                 o_busy,
   output logic                 o_done,
   fetch_controller_if.master   bus
);

   fetch_state_t          r_state;
   logic [ADDR_W-1:0]     r_pc;
   logic [2:0]            r_k;
   logic [BYTE_SIZE-1:0]  r_len;
   logic [23:0]           r_lo;
   logic [INSTR_SIZE-1:0] r_instr;
   logic [ADDR_W-1:0]     r_instr_pc;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_done;

   logic [ADDR_W:0]       w_seq_pc;
   logic [ADDR_W:0]       w_jump_pc;
   logic                  w_jump_ok;
   logic                  w_first_ok;
   logic                  w_jump;

   // Next-PC selection: redirect beats sequential advance; bounds use the latched length
   always_comb begin
      w_seq_pc   = {1'b0, r_pc} + (ADDR_W+1)'(INSTR_BYTES);
      w_jump_pc  = bus.redirect_valid ? {1'b0, bus.redirect_pc} : w_seq_pc;
      w_jump_ok  = word_fits(int'(w_jump_pc), int'(r_len), MEM_BYTES);
      w_first_ok = word_fits(1, int'(i_mem_rdata), MEM_BYTES);
      case (r_state)
         S_FETCH:   w_jump = bus.redirect_valid;
         S_PRESENT: w_jump = bus.redirect_valid || bus.instr_ready;
         S_DONE:    w_jump = bus.redirect_valid && !i_start;
         default:   w_jump = 1'b0;
      endcase
   end

   // ROM address: byte 0 outside FETCH, otherwise the byte currently being requested
   always_comb begin
      o_mem_addr = '0;
      if (r_state == S_FETCH && r_k < 3'd4) begin
         o_mem_addr = r_pc + ADDR_W'(r_k);
      end
   end

   // Fetch sequencer with registered handshake and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_k        <= '0;
         r_len      <= '0;
         r_lo       <= '0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else if (w_jump) begin
         // Any partial word is abandoned; the byte counter restarts at the new PC
         r_pc    <= w_jump_pc[ADDR_W-1:0];
         r_k     <= '0;
         r_valid <= 1'b0;
         if (w_jump_ok) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
         end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_LEN_RD;
                  r_busy  <= 1'b1;
               end
            end
            S_LEN_RD: r_state <= S_LEN_CAP;
            S_LEN_CAP: begin
               r_len <= i_mem_rdata;
               r_pc  <= ADDR_W'(1);
               r_k   <= '0;
               if (w_first_ok) begin
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_FETCH: begin
               if (r_k == 3'd4) begin
                  r_instr    <= {i_mem_rdata, r_lo};
                  r_instr_pc <= r_pc;
                  r_valid    <= 1'b1;
                  r_state    <= S_PRESENT;
               end else begin
                  // Bytes arrive b0 first; shifting in from the top leaves {b2,b1,b0}
                  if (r_k != 3'd0) begin
                     r_lo <= {i_mem_rdata, r_lo[23:8]};
                  end
                  r_k <= r_k + 3'd1;
               end
            end
            S_PRESENT: ;
            S_DONE: begin
               if (i_start) begin
                  r_state <= S_LEN_RD;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;
   assign bus.instr_valid = r_valid;
   assign o_busy          = r_busy;
   assign o_done          = r_done;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - table, directed and randomized checks of fetch_controller
`timescale 1ns/1ps
module tb_fetch_controller;
   import fetch_pkg::*;

   localparam int MEM_BYTES = 128;
   localparam int ADDR_W    = 7;
   localparam int M_IDLE = 0, M_WAIT = 1, M_PRES = 2, M_DONE = 3;

   typedef struct {
      int len;
      int words;
      int first;
      int dn;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata = 8'h00;
   logic              busy, done;
   logic [7:0]        rom [MEM_BYTES];

   int n_err = 0, n_chk = 0;
   int m_mode, m_at, m_fetch, m_pc, m_len, m_cyc, n_hs;

   fetch_controller_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_controller #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .o_mem_addr  (mem_addr),
      .i_mem_rdata (mem_rdata),
      .o_busy      (busy),
      .o_done      (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= rom[mem_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic fits(input int pc);
      return (pc + 4 <= m_len) && (pc + 4 <= MEM_BYTES);
   endfunction

   function automatic logic [31:0] word_at(input int pc);
      return {rom[pc+3], rom[pc+2], rom[pc+1], rom[pc]};
   endfunction

   // Next expected event: a word dv cycles out, or done df cycles out if none fits
   task automatic launch(input int pc, input int dv, input int df);
      m_pc = pc;
      if (fits(pc)) begin
         m_mode  = M_WAIT;
         m_at    = m_cyc + dv;
         m_fetch = m_cyc + df;
      end else begin
         m_mode = M_DONE;
         m_at   = m_cyc + df;
      end
   endtask

   // One cycle: compare outputs with the model, drive inputs, advance model and clock
   task automatic step(input logic st, input logic rdy, input logic rv, input int rpc);
      logic ev, ed, eb, hs, acc;
      if (m_mode == M_WAIT && m_cyc >= m_at) m_mode = M_PRES;
      ev = (m_mode == M_PRES);
      ed = (m_mode == M_DONE && m_cyc >= m_at);
      eb = (m_mode != M_IDLE) && !ed;
      chk("valid/done/busy", {bus.instr_valid, done, busy}, {ev, ed, eb});
      if (ev) begin
         chk("instr", bus.instr, word_at(m_pc));
         chk("instr_pc", bus.instr_pc, m_pc);
      end
      start              = st;
      bus.instr_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = 7'(rpc);
      hs  = ev && rdy;
      acc = rv && ((m_mode == M_WAIT && m_cyc >= m_fetch) || ev || ed);
      if (hs) n_hs++;
      if (st && (m_mode == M_IDLE || ed)) begin
         m_len = int'(rom[0]);
         launch(1, 8, 3);
      end else if (acc) begin
         launch(rpc, 6, 1);
      end else if (hs) begin
         launch(m_pc + 4, 6, 1);
      end
      @(negedge clk);
      m_cyc++;
   endtask

   vec_t tbl [6];
   int   first, dn, h0;
   logic can;

   initial begin
      tbl[0] = '{9, 2, 8, 15};
      tbl[1] = '{7, 1, 8, 9};
      tbl[2] = '{0, 0, -1, 3};
      tbl[3] = '{4, 0, -1, 3};
      tbl[4] = '{5, 1, 8, 9};
      tbl[5] = '{13, 3, 8, 21};
      for (int i = 0; i < MEM_BYTES; i++) rom[i] = 8'(i * 37 + 11);
      rom[1] = 8'h13; rom[2] = 8'h00; rom[3] = 8'h00; rom[4] = 8'h00;
      rom[5] = 8'h93; rom[6] = 8'h00; rom[7] = 8'h10; rom[8] = 8'h00;
      bus.instr_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      m_mode = M_IDLE; m_at = 0; m_fetch = 0; m_pc = 0; m_len = 0; m_cyc = 0; n_hs = 0;

      repeat (2) @(negedge clk);
      chk("reset outputs", {bus.instr, bus.instr_pc, bus.instr_valid, busy, done, mem_addr}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Length table: first run from IDLE, the rest restart from DONE
      foreach (tbl[i]) begin
         rom[0] = 8'(tbl[i].len);
         h0 = n_hs; first = -1; dn = -1;
         step(1'b1, 1'b1, 1'b0, 0);
         for (int r = 1; r <= 30; r++) begin
            if (bus.instr_valid && first < 0) first = r;
            if (done && dn < 0) dn = r;
            step(1'b0, 1'b1, 1'b0, 0);
         end
         chk($sformatf("tbl%0d words", i), n_hs - h0, tbl[i].words);
         chk($sformatf("tbl%0d first valid", i), first, tbl[i].first);
         chk($sformatf("tbl%0d done cycle", i), dn, tbl[i].dn);
      end

      // Backpressure: three stalled cycles on the first word
      rom[0] = 8'd9;
      step(1'b1, 1'b0, 1'b0, 0);
      for (int r = 1; r <= 10; r++) step(1'b0, 1'b0, 1'b0, 0);
      chk("bp held word", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 7'd1, 32'h00000013});
      step(1'b0, 1'b1, 1'b0, 0);
      for (int r = 12; r <= 15; r++) step(1'b0, 1'b1, 1'b0, 0);
      chk("bp gap", bus.instr_valid, 1'b0);
      step(1'b0, 1'b1, 1'b0, 0);
      chk("bp second word", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 7'd5, 32'h00100093});
      for (int r = 0; r < 4; r++) step(1'b0, 1'b1, 1'b0, 0);

      // Redirect with same-cycle handshake, then redirect out of bounds
      h0 = n_hs;
      step(1'b1, 1'b1, 1'b0, 0);
      for (int r = 1; r <= 13; r++) step(1'b0, 1'b1, 1'b0, 0);
      chk("rd at pc5", {bus.instr_valid, bus.instr_pc}, {1'b1, 7'd5});
      step(1'b0, 1'b1, 1'b1, 1);
      for (int r = 15; r <= 19; r++) step(1'b0, 1'b0, 1'b0, 0);
      chk("rd back to pc1", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 7'd1, 32'h00000013});
      chk("rd transfers", n_hs - h0, 2);
      step(1'b0, 1'b0, 1'b1, 6);
      chk("rd oob done", {bus.instr_valid, done}, {1'b0, 1'b1});

      // Reset while assembling byte 2 of the first word
      step(1'b1, 1'b1, 1'b0, 0);
      for (int r = 1; r <= 4; r++) step(1'b0, 1'b1, 1'b0, 0);
      chk("k2 address", mem_addr, 7'd3);
      rst = 1'b1;
      #1;
      chk("mid-run reset", {bus.instr, bus.instr_pc, bus.instr_valid, busy, done, mem_addr}, 0);
      @(negedge clk);
      rst = 1'b0;
      m_mode = M_IDLE;
      step(1'b1, 1'b1, 1'b0, 0);
      for (int r = 1; r <= 7; r++) step(1'b0, 1'b1, 1'b0, 0);
      chk("rerun first word", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 7'd1, 32'h00000013});
      for (int r = 0; r < 10; r++) step(1'b0, 1'b1, 1'b0, 0);

      // Randomized traffic against the transfer-level model
      for (int n = 0; n < 4000; n++) begin
         logic rdy, rv;
         int rpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 40));
         can = (m_mode == M_IDLE) || (m_mode == M_DONE && m_cyc >= m_at);
         if (can && $urandom_range(0, 3) == 0) begin
            rom[0] = 8'($urandom_range(0, 48));
            if ($urandom_range(0, 7) == 0) rom[0] = 8'($urandom_range(120, 255));
            for (int i = 1; i < MEM_BYTES; i++) rom[i] = 8'($urandom);
            step(1'b1, rdy, rv, rpc);
         end else begin
            step($urandom_range(0, 15) == 0, rdy, rv, rpc);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
